inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 13 +
 rtl/inst_fetch.sv | 76 +++++++
 tb/tb_inst_fetch.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, NOP word and instruction width.
package inst_fetch_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, BOOT/RUN/HOLD control and the IF/ID register.
// Optional FETCH_STALL_CNT_EN adds a saturating 16-bit stall-cycle counter output.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic [31:0]       rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic [31:0]       if_id_pc,
  output logic [INST_W-1:0] if_id_inst,
`ifdef FETCH_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              if_id_valid
);

  fetch_state_t state;
  logic [31:0]  pc;

  assign rom_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      if_id_pc    <= 32'h0;
      if_id_inst  <= NOP;
      if_id_valid <= 1'b0;
    end else if (branch_taken) begin
      // Redirect beats a stall: the held instruction is on the wrong path.
      state       <= ST_RUN;
      pc          <= {branch_target[31:2], 2'b00};
      if_id_pc    <= 32'h0;
      if_id_inst  <= NOP;
      if_id_valid <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state       <= ST_RUN;
          if_id_pc    <= 32'h0;
          if_id_inst  <= NOP;
          if_id_valid <= 1'b0;
        end
        ST_RUN, ST_HOLD: begin
          if (stall) begin
            state <= ST_HOLD;
          end else begin
            state       <= ST_RUN;
            if_id_pc    <= pc;
            if_id_inst  <= rom_inst;
            if_id_valid <= 1'b1;
            pc          <= pc + 32'd4;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0;
    end else if (stall && !branch_taken && state != ST_BOOT && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch with a small behavioural instruction ROM.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  logic [31:0] rom [64];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign rom_inst = rom[rom_addr[7:2]];

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .rom_addr     (rom_addr),
    .rom_inst     (rom_inst),
    .if_id_pc     (if_id_pc),
    .if_id_inst   (if_id_inst),
`ifdef FETCH_STALL_CNT_EN
    .stall_cnt    (stall_cnt),
`endif
    .if_id_valid  (if_id_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc_e,
                            input logic [31:0] inst_e, input logic v_e);
    check({tag, ".pc"}, if_id_pc, pc_e);
    check({tag, ".inst"}, if_id_inst, inst_e);
    check({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, v_e});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA500_0000 + i;
    rom[0] = 32'h0000_0000;
    rom[1] = 32'h1400_1021;
    rom[2] = 32'h3400_1062;

    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    #12;
    check_ifid("reset", 32'h0, 32'h0, 1'b0);
    check("reset.rom_addr", rom_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Free run from reset: BOOT bubble, then sequential fetch
    step(); check_ifid("boot", 32'h0, 32'h0, 1'b0);
    $display("boot bubble: pc=%08h valid=%0b", if_id_pc, if_id_valid);
    step(); check_ifid("run0", 32'h00, 32'h0000_0000, 1'b1);
    $display("fetch: pc=%08h inst=%08h", if_id_pc, if_id_inst);
    step(); check_ifid("run1", 32'h04, 32'h1400_1021, 1'b1);
    $display("fetch: pc=%08h inst=%08h", if_id_pc, if_id_inst);

    // Stall two cycles while IF/ID holds 0x04
    stall = 1'b1;
    step(); check_ifid("stall1", 32'h04, 32'h1400_1021, 1'b1);
    check("stall1.rom_addr", rom_addr, 32'h08);
    step(); check_ifid("stall2", 32'h04, 32'h1400_1021, 1'b1);
    check("stall2.rom_addr", rom_addr, 32'h08);
`ifdef FETCH_STALL_CNT_EN
    check("stall_cnt", {16'h0, stall_cnt}, 32'd2);
`endif
    $display("stall: pc=%08h held inst=%08h", rom_addr, if_id_inst);
    stall = 1'b0;
    step(); check_ifid("resume", 32'h08, 32'h3400_1062, 1'b1);
    check("resume.rom_addr", rom_addr, 32'h0C);
    $display("resume: pc=%08h inst=%08h", if_id_pc, if_id_inst);

    // Branch to 0x10
    branch_taken = 1'b1; branch_target = 32'h10;
    step(); check_ifid("br.flush", 32'h0, 32'h0, 1'b0);
    check("br.rom_addr", rom_addr, 32'h10);
    branch_taken = 1'b0;
    step(); check_ifid("br.target", 32'h10, 32'hA500_0004, 1'b1);
    $display("branch: pc=%08h inst=%08h", if_id_pc, if_id_inst);

    // Branch with stall; misaligned target bits are dropped
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h07;
    step(); check_ifid("brst.flush", 32'h0, 32'h0, 1'b0);
    check("brst.rom_addr", rom_addr, 32'h04);
    stall = 1'b0; branch_taken = 1'b0;
    step(); check_ifid("brst.target", 32'h04, 32'h1400_1021, 1'b1);
    $display("branch+stall: pc=%08h inst=%08h", if_id_pc, if_id_inst);

    // Reset between edges during HOLD
    stall = 1'b1;
    step(); check_ifid("hold", 32'h04, 32'h1400_1021, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_ifid("mid_rst", 32'h0, 32'h0, 1'b0);
    check("mid_rst.rom_addr", rom_addr, 32'h0);
`ifdef FETCH_STALL_CNT_EN
    check("mid_rst.stall_cnt", {16'h0, stall_cnt}, 32'd0);
`endif
    $display("async reset: pc=%08h valid=%0b", rom_addr, if_id_valid);
    stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(); check_ifid("reboot", 32'h0, 32'h0, 1'b0);
    step(); check_ifid("rerun", 32'h00, 32'h0000_0000, 1'b1);
    $display("reboot: pc=%08h valid=%0b", if_id_pc, if_id_valid);

    // PC wrap at top of address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step(); check("wrap.rom_addr0", rom_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    step(); check_ifid("wrap", 32'hFFFF_FFFC, 32'hA500_003F, 1'b1);
    check("wrap.rom_addr1", rom_addr, 32'h0);
    $display("wrap: pc=%08h next=%08h", if_id_pc, rom_addr);

    // Redirect taken during BOOT; stall during BOOT not counted
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h20; stall = 1'b1;
    step(); check_ifid("bootbr", 32'h0, 32'h0, 1'b0);
    check("bootbr.rom_addr", rom_addr, 32'h20);
    branch_taken = 1'b0;
`ifdef FETCH_STALL_CNT_EN
    check("boot.stall_cnt", {16'h0, stall_cnt}, 32'd0);
    step(); step(); step();
    check("stall_cnt3", {16'h0, stall_cnt}, 32'd3);
`endif
    stall = 1'b0;
    step(); check_ifid("bootbr.target", 32'h20, 32'hA500_0008, 1'b1);
    $display("boot branch: pc=%08h inst=%08h", if_id_pc, if_id_inst);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
